// File: rtl/delay_trig_seq.sv
// Host-to-chip sequencer for an AD9500-class programmable delay line.
// Loads delay codes with setup/latch timing and issues held-off triggers.
module delay_trig_seq #(
    parameter int SETUP_CYC = 2,
    parameter int LE_CYC    = 2,
    parameter int TRIG_CYC  = 2,
    parameter int HOLD_CYC  = 8,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [7:0]       DELAY_IN,
    output logic             LOAD_RDY,
    input  logic             TRIG_REQ,
    output logic [7:0]       D,
    output logic             LE,
    output logic             TRIG,
    output logic             BUSY,
    output logic [7:0]       CUR_DELAY,
    output logic [CNT_W-1:0] TRIG_CNT,
    output logic [CNT_W-1:0] DROP_CNT
);

    localparam int M1   = (SETUP_CYC > LE_CYC) ? SETUP_CYC : LE_CYC;
    localparam int M2   = (TRIG_CYC > HOLD_CYC) ? TRIG_CYC : HOLD_CYC;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] S_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] L_LD = TW'(LE_CYC - 1);
    localparam logic [TW-1:0] T_LD = TW'(TRIG_CYC - 1);
    localparam logic [TW-1:0] H_LD = TW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LATCH,
        FIRE,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [TW-1:0]     cnt;
    logic [TW-1:0]     cnt_n;
    logic [7:0]        d_n;
    logic [7:0]        cur_n;
    logic              le_n;
    logic              trig_n;
    logic              rdy_n;
    logic [CNT_W-1:0]  tcnt_n;
    logic [CNT_W-1:0]  drop_n;
    logic              done;

    assign done = (cnt == '0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = D;
        cur_n   = CUR_DELAY;
        le_n    = LE;
        trig_n  = TRIG;
        tcnt_n  = TRIG_CNT;
        drop_n  = DROP_CNT;

        // Requests arriving while busy are counted, never queued.
        if (TRIG_REQ && state != IDLE && DROP_CNT != '1) begin
            drop_n = DROP_CNT + CNT_W'(1);
        end

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (TRIG_REQ) begin
                    state_n = FIRE;
                    cnt_n   = T_LD;
                    trig_n  = 1'b1;
                    tcnt_n  = TRIG_CNT + CNT_W'(1);
                end else if (LOAD) begin
                    state_n = SETUP;
                    cnt_n   = S_LD;
                    d_n     = DELAY_IN;
                end
            end
            SETUP: begin
                if (done) begin
                    state_n = LATCH;
                    cnt_n   = L_LD;
                    le_n    = 1'b1;
                end else begin
                    cnt_n = cnt - TW'(1);
                end
            end
            LATCH: begin
                if (done) begin
                    state_n = IDLE;
                    le_n    = 1'b0;
                    cur_n   = D;
                end else begin
                    cnt_n = cnt - TW'(1);
                end
            end
            FIRE: begin
                if (done) begin
                    state_n = HOLD;
                    cnt_n   = H_LD;
                    trig_n  = 1'b0;
                end else begin
                    cnt_n = cnt - TW'(1);
                end
            end
            HOLD: begin
                if (done) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                le_n    = 1'b0;
                trig_n  = 1'b0;
            end
        endcase

        rdy_n = (state_n == IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            D         <= '0;
            LE        <= 1'b0;
            TRIG      <= 1'b0;
            CUR_DELAY <= '0;
            TRIG_CNT  <= '0;
            DROP_CNT  <= '0;
            LOAD_RDY  <= 1'b1;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            D         <= d_n;
            LE        <= le_n;
            TRIG      <= trig_n;
            CUR_DELAY <= cur_n;
            TRIG_CNT  <= tcnt_n;
            DROP_CNT  <= drop_n;
            LOAD_RDY  <= rdy_n;
            BUSY      <= ~rdy_n;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            assert (!(LE && TRIG));
        end
    end
`endif

endmodule
